// File: rtl/mem_access_pkg.sv
// Shared widths, opcodes, funct3 codes, flow commands and FSM states
// for the load/store stage.
package mem_access_pkg;

    localparam int CPU_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int FLOW_WIDTH     = 2;

    localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = 2'd0;
    localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = 2'd1;
    localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = 2'd2;

    localparam logic [6:0] INST_LOAD  = 7'b0000011;
    localparam logic [6:0] INST_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane steering: load extraction/extension, store byte enables
// and lane replication. Purely combinational.
module mem_lane_fmt
    import mem_access_pkg::*;
(
    input  logic [2:0]           funct3,
    input  logic [1:0]           addr_idx,
    input  logic [CPU_WIDTH-1:0] rdata,
    input  logic [CPU_WIDTH-1:0] wdata_in,
    output logic [CPU_WIDTH-1:0] ld_data,
    output logic [3:0]           be,
    output logic [CPU_WIDTH-1:0] wdata
);

    logic [CPU_WIDTH-1:0] shifted;
    logic [7:0]           byte_v;
    logic [15:0]          half_v;

    // Pick the addressed byte/half and extend it per load type
    always_comb begin
        shifted = rdata >> {addr_idx, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = addr_idx[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   ld_data = {{24{byte_v[7]}}, byte_v};
            F3_LH:   ld_data = {{16{half_v[15]}}, half_v};
            F3_LBU:  ld_data = {24'd0, byte_v};
            F3_LHU:  ld_data = {16'd0, half_v};
            default: ld_data = rdata;
        endcase
    end

    // Byte enables and replicated write data for stores
    always_comb begin
        case (funct3)
            F3_SB: begin
                be    = 4'b0001 << addr_idx;
                wdata = {4{wdata_in[7:0]}};
            end
            F3_SH: begin
                be    = addr_idx[1] ? 4'b1100 : 4'b0011;
                wdata = {2{wdata_in[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = wdata_in;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Load/store stage with single-outstanding bus handshake.
// Optional MEM_MISALIGN_CHECK_EN blocks misaligned half/word accesses.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CPU_WIDTH-1:0]      inst_i,
    input  logic [FLOW_WIDTH-1:0]     flow_mem_i,
    input  logic [CPU_WIDTH-1:0]      mem_addr_i,
    input  logic [CPU_WIDTH-1:0]      mem_wdata_i,
    input  logic                      reg_wr_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] reg_wr_adder_i,
    input  logic [CPU_WIDTH-1:0]      reg_wr_data_i,
    output logic                      bus_req_o,
    output logic                      bus_we_o,
    output logic [CPU_WIDTH-1:0]      bus_addr_o,
    output logic [3:0]                bus_be_o,
    output logic [CPU_WIDTH-1:0]      bus_wdata_o,
    input  logic                      bus_ack_i,
    input  logic [CPU_WIDTH-1:0]      bus_rdata_i,
    output logic                      reg_wr_en_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_wr_adder_o,
    output logic [CPU_WIDTH-1:0]      reg_wr_data_o,
    output logic [1:0]                mem_addr_index_o,
    output logic                      no_writing_mem_o,
    output logic                      stall_req_o,
    output logic                      misalign_o
);

    mem_state_e           state_q, state_d;
    logic [CPU_WIDTH-1:0] rdata_q, addr_q, wdata_q;
    logic [3:0]           be_q;
    logic                 we_q;

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 is_load, is_store, is_mem;
    logic                 misal, issue, refresh;
    logic                 latch, capture, hold;
    logic [CPU_WIDTH-1:0] ld_fmt, wdata_c;
    logic [3:0]           be_c;
    logic                 unused_bits;

    assign opcode      = inst_i[6:0];
    assign funct3      = inst_i[14:12];
    assign is_load     = opcode == INST_LOAD;
    assign is_store    = opcode == INST_STORE;
    assign is_mem      = is_load | is_store;
    assign refresh     = flow_mem_i == FLOW_REFRESH;
    assign unused_bits = ^{inst_i[31:15], inst_i[11:7]};

`ifdef MEM_MISALIGN_CHECK_EN
    logic is_byte, is_half;
    assign is_byte = is_load ? (funct3 == F3_LB || funct3 == F3_LBU)
                             : (funct3 == F3_SB);
    assign is_half = is_load ? (funct3 == F3_LH || funct3 == F3_LHU)
                             : (funct3 == F3_SH);
    assign misal   = is_mem & ((is_half & mem_addr_i[0]) |
                     (~is_byte & ~is_half & (|mem_addr_i[1:0])));
`else
    assign misal   = 1'b0;
`endif

    assign issue      = is_mem & ~misal;
    assign misalign_o = misal;

    mem_lane_fmt u_fmt (
        .funct3   (funct3),
        .addr_idx (mem_addr_i[1:0]),
        .rdata    (bus_rdata_i),
        .wdata_in (mem_wdata_i),
        .ld_data  (ld_fmt),
        .be       (be_c),
        .wdata    (wdata_c)
    );

    // While an access is outstanding the bus sees the captured request
    assign bus_addr_o  = hold ? addr_q  : {mem_addr_i[31:2], 2'b00};
    assign bus_be_o    = hold ? be_q    : be_c;
    assign bus_wdata_o = hold ? wdata_q : wdata_c;
    assign bus_we_o    = hold ? we_q    : is_store;

    assign reg_wr_adder_o   = reg_wr_adder_i;
    assign mem_addr_index_o = mem_addr_i[1:0];
    assign no_writing_mem_o = ~is_store;

    // State, formatted read data and captured bus request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) rdata_q <= ld_fmt;
            if (capture) begin
                addr_q  <= {mem_addr_i[31:2], 2'b00};
                wdata_q <= wdata_c;
                be_q    <= be_c;
                we_q    <= is_store;
            end
        end
    end

    // Next state, handshake and write-back outputs
    always_comb begin
        state_d       = state_q;
        bus_req_o     = 1'b0;
        stall_req_o   = 1'b0;
        latch         = 1'b0;
        capture       = 1'b0;
        hold          = 1'b0;
        reg_wr_en_o   = reg_wr_en_i;
        reg_wr_data_o = reg_wr_data_i;
        unique case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    bus_req_o   = 1'b1;
                    stall_req_o = 1'b1;
                    capture     = 1'b1;
                    reg_wr_en_o = 1'b0;
                    if (bus_ack_i) begin
                        latch   = ~refresh;
                        state_d = refresh ? ST_IDLE : ST_DONE;
                    end else begin
                        state_d = refresh ? ST_DRAIN : ST_WAIT;
                    end
                end else if (misal) begin
                    reg_wr_en_o = 1'b0;
                end
            end
            ST_WAIT: begin
                bus_req_o   = 1'b1;
                stall_req_o = 1'b1;
                hold        = 1'b1;
                reg_wr_en_o = 1'b0;
                if (bus_ack_i) begin
                    latch   = ~refresh;
                    state_d = refresh ? ST_IDLE : ST_DONE;
                end else if (refresh) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                bus_req_o   = 1'b1;
                stall_req_o = 1'b1;
                hold        = 1'b1;
                reg_wr_en_o = 1'b0;
                if (bus_ack_i) state_d = ST_IDLE;
            end
            ST_DONE: begin
                if (is_load) reg_wr_data_o = rdata_q;
                if (refresh) reg_wr_en_o = 1'b0;
                if (flow_mem_i != FLOW_STOP) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (is_store) reg_wr_en_o = 1'b0;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Load/store stage between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Decodes the load/store instruction and drives a single-outstanding data-bus request/ack handshake.
- Formats load data and forwards the write-back fields (reg write, mem_addr_index, no_writing_mem) to MEM/WB.
- Raises a stall request to the flow controller while a bus access is outstanding.

Parameters:
- none; widths come from shared macros: `CPU_WIDTH` (32), `REG_ADDR_WIDTH` (5), `FLOW_WIDTH`.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- inst_i  input  CPU_WIDTH  instruction in MEM; opcode [6:0], funct3 [14:12]
- flow_mem_i  input  FLOW_WIDTH  flow command for this stage: `FLOW_WORK`/`FLOW_STOP`/`FLOW_REFRESH`
- mem_addr_i  input  CPU_WIDTH  effective address (ALU result)
- mem_wdata_i  input  CPU_WIDTH  store data (rs2)
- reg_wr_en_i / reg_wr_adder_i / reg_wr_data_i  input  1/REG_ADDR_WIDTH/CPU_WIDTH  write-back fields from EX
- bus_req_o  output  1  data-bus request
- bus_we_o  output  1  1 = store
- bus_addr_o  output  CPU_WIDTH  word-aligned address, {mem_addr_i[31:2],2'b00}
- bus_be_o  output  4  byte enables
- bus_wdata_o  output  CPU_WIDTH  lane-replicated store data
- bus_ack_i  input  1  access complete; bus_rdata_i valid in the same cycle
- bus_rdata_i  input  CPU_WIDTH  read word
- reg_wr_en_o / reg_wr_adder_o / reg_wr_data_o  output  1/REG_ADDR_WIDTH/CPU_WIDTH  to MEM/WB
- mem_addr_index_o  output  2  mem_addr_i[1:0]
- no_writing_mem_o  output  1  1 when the instruction is not a store
- stall_req_o  output  1  request to freeze IF..MEM
- misalign_o  output  1  misaligned access flag; tied 0 without the optional feature

Behaviour:
- Reset is asynchronous and active-low: state=IDLE, latched rdata=0, all registered outputs 0, bus_req_o=0.
- Decode: LOAD opcode 7'b0000011, STORE opcode 7'b0100011; any other opcode is pass-through (no bus activity).
- Pass-through: reg_* outputs equal reg_*_i combinationally; stall_req_o=0.
- FSM states:
  - IDLE: on a LOAD/STORE, assert bus_req_o and stall_req_o (combinational).
    - bus_ack_i=1 in the same cycle: latch rdata, go to DONE.
    - Otherwise go to WAIT.
  - WAIT: bus_req_o=1, stall_req_o=1, bus_addr_o/be/wdata/we held stable (EX/MEM is frozen). On bus_ack_i, latch rdata, go to DONE.
  - DONE: bus_req_o=0, stall_req_o=0; outputs driven from the latched data.
    - flow_mem_i=`FLOW_WORK`: go to IDLE (instruction retires into MEM/WB this cycle).
    - flow_mem_i=`FLOW_STOP`: stay in DONE, holding the result (prevents re-issuing the access).
  - DRAIN: entered from IDLE-with-request or WAIT when flow_mem_i=`FLOW_REFRESH` and no ack has arrived. Keeps bus_req_o=1 until ack, discards data, asserts stall_req_o, then returns to IDLE.
- REFRESH coinciding with ack: data discarded, go to IDLE.
- REFRESH in DONE: go to IDLE.
- Minimum load/store latency: 1 stall cycle when ack arrives in the same cycle as the request.
- Load format, by funct3 and addr[1:0] lane:
  - LB (000): sign-extend byte.
  - LH (001): sign-extend half; lane = addr[1].
  - LW (010): full word.
  - LBU (100): zero-extend byte.
  - LHU (101): zero-extend half.
  - Other funct3 values: treated as LW.
- Load write-back: reg_wr_data_o = formatted data; reg_wr_en_o = reg_wr_en_i.
- Store: bus_we_o=1; reg_wr_en_o=0; no_writing_mem_o=0.
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{byte}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{half}}.
  - SW: be = 4'b1111.
- Ignored input: bus_ack_i while bus_req_o=0 has no effect.
- Reset mid-access: FSM returns to IDLE immediately; bus_req_o drops.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issue no bus request.
  - misalign_o=1 for that cycle; reg_wr_en_o=0; stall_req_o=0.
- Undefined:
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].
  - misalign_o is held at 0.

Decomposition:
- Shared defines file (existing): opcode constants `INST_LOAD`/`INST_STORE`, funct3 constants `LB`..`LHU`/`SB`..`SW`, FSM state encodings, and the `FLOW_*` codes.
- One sub-module, mem_lane_fmt: purely combinational load extraction/extension and store byte-enable/replication.
- The FSM stays in mem_access.

Test Plan:
- LW, addr 0x100, ack in the same cycle, rdata 0xDEADBEEF → stall_req_o high for 1 cycle; reg_wr_data_o=0xDEADBEEF in DONE; back to IDLE.
- LB, addr 0x103, rdata 0x80FF_FF7F, ack after 3 cycles → bus_addr_o=0x100 stable throughout; reg_wr_data_o=0xFFFFFF80; stall high for 3 cycles.
- SH, addr 0x202, wdata 0x1234ABCD → bus_be_o=4'b1100, bus_wdata_o=0xABCDABCD, bus_we_o=1, reg_wr_en_o=0, no_writing_mem_o=0.
- LHU, addr 0x10, ack delayed; `FLOW_REFRESH` in WAIT → DRAIN; bus_req_o held until ack; no register write; then IDLE.
- LW completes, then `FLOW_STOP` for 2 cycles in DONE → outputs held, bus_req_o stays 0 (no second access).
- With MEM_MISALIGN_CHECK_EN, LW at 0x101 → misalign_o=1, bus_req_o=0, reg_wr_en_o=0; without the macro → bus_addr_o=0x100, normal load.
